// File: rtl/sps_pkg.sv
// Shared encodings for the stone-paper-scissors match host: core result codes,
// round codes, move codes and FSM states.
package sps_pkg;

  localparam logic [7:0] RES_TIE = 8'd0;
  localparam logic [7:0] RES_P1  = 8'd49;
  localparam logic [7:0] RES_P2  = 8'd50;
  localparam logic [7:0] RES_INV = 8'd63;

  localparam logic [1:0] MV_STONE    = 2'b00;
  localparam logic [1:0] MV_PAPER    = 2'b01;
  localparam logic [1:0] MV_SCISSORS = 2'b10;

  typedef enum logic [1:0] {
    RC_TIE = 2'b00,
    RC_P1  = 2'b01,
    RC_P2  = 2'b10,
    RC_BAD = 2'b11
  } round_code_t;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DRIVE   = 2'd1,
    S_RELEASE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/sps_match_host_if.sv
// Host-side request/score bus plus the move/start/result link to the game core.
interface sps_match_host_if #(parameter int SCORE_W = 4);
  logic [1:0]         p1_sel;
  logic [1:0]         p2_sel;
  logic               round_req;
  logic               match_clear;
  logic [7:0]         game_result;
  logic [1:0]         game_p1_move;
  logic [1:0]         game_p2_move;
  logic               game_start;
  logic               round_ready;
  logic               round_valid;
  logic [1:0]         round_code;
  logic [SCORE_W-1:0] p1_score;
  logic [SCORE_W-1:0] p2_score;
  logic [SCORE_W-1:0] tie_count;
  logic               match_done;
  logic [1:0]         match_winner;
  logic               proto_err;

  modport master (
    input  p1_sel, p2_sel, round_req, match_clear, game_result,
    output game_p1_move, game_p2_move, game_start, round_ready, round_valid,
           round_code, p1_score, p2_score, tie_count, match_done, match_winner,
           proto_err
  );

  modport slave (
    output p1_sel, p2_sel, round_req, match_clear, game_result,
    input  game_p1_move, game_p2_move, game_start, round_ready, round_valid,
           round_code, p1_score, p2_score, tie_count, match_done, match_winner,
           proto_err
  );
endinterface

// File: rtl/sps_result_decoder.sv
// Maps the core's 8-bit result code onto a 2-bit round code; flags codes the
// core should never produce.
module sps_result_decoder
  import sps_pkg::*;
(
  input  logic [7:0]  code,
  output round_code_t round_code,
  output logic        bad_code
);
  always_comb begin
    round_code = RC_BAD;
    bad_code   = 1'b0;
    case (code)
      RES_TIE: round_code = RC_TIE;
      RES_P1:  round_code = RC_P1;
      RES_P2:  round_code = RC_P2;
      RES_INV: round_code = RC_BAD;
      default: bad_code   = 1'b1;
    endcase
  end
endmodule

// File: rtl/sps_match_host.sv
// Drives one game-core round at a time, samples its result on a fixed schedule,
// keeps saturating scores and declares the match winner.
module sps_match_host
  import sps_pkg::*;
#(
  parameter int WINS_TO_MATCH = 2,
  parameter int SCORE_W       = 4,
  parameter int SAMPLE_DLY    = 2,
  parameter int GAP_CYCLES    = 1
) (
  input  logic clk,
  input  logic rst,
  sps_match_host_if.master bus
);
  localparam int CNT_MAX = (SAMPLE_DLY > GAP_CYCLES) ? SAMPLE_DLY : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt;
  logic               accept, sample, clear;
  round_code_t        dec_code;
  logic               dec_bad;
  logic [SCORE_W-1:0] p1_nxt, p2_nxt, tie_nxt;

  sps_result_decoder u_dec (
    .code       (bus.game_result),
    .round_code (dec_code),
    .bad_code   (dec_bad)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  // Result sampling is purely time-based: a tie code is the same as the idle bus.
  always_comb begin
    state_d = state;
    accept  = 1'b0;
    sample  = 1'b0;
    clear   = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.match_clear) clear = 1'b1;
        else if (bus.round_req && bus.round_ready) begin
          accept  = 1'b1;
          state_d = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (cnt == CNT_W'(SAMPLE_DLY - 1)) begin
          sample  = 1'b1;
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (cnt == CNT_W'(GAP_CYCLES - 1))
          state_d = bus.match_done ? S_DONE : S_IDLE;
      end
      S_DONE: begin
        if (bus.match_clear) begin
          clear   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    p1_nxt  = bus.p1_score;
    p2_nxt  = bus.p2_score;
    tie_nxt = bus.tie_count;
    if (dec_code == RC_P1  && bus.p1_score  != '1) p1_nxt  = bus.p1_score  + 1'b1;
    if (dec_code == RC_P2  && bus.p2_score  != '1) p2_nxt  = bus.p2_score  + 1'b1;
    if (dec_code == RC_TIE && bus.tie_count != '1) tie_nxt = bus.tie_count + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt              <= '0;
      bus.game_p1_move <= '0;
      bus.game_p2_move <= '0;
      bus.game_start   <= 1'b0;
      bus.round_ready  <= 1'b0;
      bus.round_valid  <= 1'b0;
      bus.round_code   <= '0;
      bus.p1_score     <= '0;
      bus.p2_score     <= '0;
      bus.tie_count    <= '0;
      bus.match_done   <= 1'b0;
      bus.match_winner <= '0;
      bus.proto_err    <= 1'b0;
    end else begin
      cnt             <= (state_d != state) ? '0 : cnt + 1'b1;
      bus.round_ready <= (state_d == S_IDLE);
      bus.round_valid <= sample;
      if (accept) begin
        bus.game_p1_move <= bus.p1_sel;
        bus.game_p2_move <= bus.p2_sel;
        bus.game_start   <= 1'b1;
      end
      if (sample) begin
        bus.game_start <= 1'b0;
        bus.round_code <= dec_code;
        bus.p1_score   <= p1_nxt;
        bus.p2_score   <= p2_nxt;
        bus.tie_count  <= tie_nxt;
        if (dec_bad) bus.proto_err <= 1'b1;
        if (!bus.match_done) begin
          if (p1_nxt >= SCORE_W'(WINS_TO_MATCH)) begin
            bus.match_done   <= 1'b1;
            bus.match_winner <= RC_P1;
          end else if (p2_nxt >= SCORE_W'(WINS_TO_MATCH)) begin
            bus.match_done   <= 1'b1;
            bus.match_winner <= RC_P2;
          end
        end
      end
      if (clear) begin
        bus.p1_score     <= '0;
        bus.p2_score     <= '0;
        bus.tie_count    <= '0;
        bus.match_done   <= 1'b0;
        bus.match_winner <= '0;
        bus.proto_err    <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sps_match_host.sv
// Scoreboard bench for sps_match_host with a behavioural game-core model that
// can be forced to return arbitrary result codes.
module tb_sps_match_host;
  import sps_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sps_match_host_if #(.SCORE_W(4)) bus ();

  sps_match_host #(
    .WINS_TO_MATCH(2), .SCORE_W(4), .SAMPLE_DLY(2), .GAP_CYCLES(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [1:0] code;
    logic [3:0] p1;
    logic [3:0] p2;
    logic [3:0] tie;
    logic       done;
    logic [1:0] win;
    logic       perr;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  logic       ovr_en   = 1'b0;
  logic [7:0] ovr_code = 8'd0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] core_res(input logic [1:0] a, input logic [1:0] b);
    if (a == 2'b11 || b == 2'b11) return 8'd63;
    if (a == b) return 8'd0;
    if ((a == 2'd0 && b == 2'd2) || (a == 2'd1 && b == 2'd0) || (a == 2'd2 && b == 2'd1))
      return 8'd49;
    return 8'd50;
  endfunction

  always_comb begin
    bus.game_result = 8'd0;
    if (bus.game_start)
      bus.game_result = ovr_en ? ovr_code : core_res(bus.game_p1_move, bus.game_p2_move);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && bus.round_valid) begin
      if (sbq.size() == 0) chk("unexpected_round_valid", 1, 0);
      else begin
        e = sbq.pop_front();
        chk("round_code",   bus.round_code,   e.code);
        chk("p1_score",     bus.p1_score,     e.p1);
        chk("p2_score",     bus.p2_score,     e.p2);
        chk("tie_count",    bus.tie_count,    e.tie);
        chk("match_done",   bus.match_done,   e.done);
        chk("match_winner", bus.match_winner, e.win);
        chk("proto_err",    bus.proto_err,    e.perr);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!bus.round_ready && k < 20) begin
      tick();
      k++;
    end
    chk("ready_timeout", bus.round_ready, 1);
  endtask

  task automatic play(input logic [1:0] a, input logic [1:0] b, input logic ov,
                      input logic [7:0] oc, input exp_t e);
    wait_ready();
    ovr_en = ov; ovr_code = oc;
    bus.p1_sel = a; bus.p2_sel = b; bus.round_req = 1'b1;
    sbq.push_back(e);
    tick();
    bus.round_req = 1'b0;
    chk("start_at_E", bus.game_start, 1);
    chk("p1_move", bus.game_p1_move, a);
    chk("p2_move", bus.game_p2_move, b);
    tick();
    chk("start_at_E1", bus.game_start, 1);
    tick();
    chk("start_low_E2", bus.game_start, 0);
    chk("valid_at_E2", bus.round_valid, 1);
    tick();
    chk("valid_pulse", bus.round_valid, 0);
    ovr_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int last;
    int w;
    logic gs_before;
    bus.p1_sel = 2'b00; bus.p2_sel = 2'b00;
    bus.round_req = 1'b0; bus.match_clear = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_start",   bus.game_start,  0);
    chk("rst_ready",   bus.round_ready, 0);
    chk("rst_valid",   bus.round_valid, 0);
    chk("rst_p1",      bus.p1_score,    0);
    chk("rst_done",    bus.match_done,  0);
    chk("rst_perr",    bus.proto_err,   0);
    rst = 1'b0;
    tick();
    chk("ready_after_rst", bus.round_ready, 1);

    // Reset asserted mid-DRIVE drops game_start asynchronously
    bus.p1_sel = MV_STONE; bus.p2_sel = MV_SCISSORS; bus.round_req = 1'b1;
    tick();
    bus.round_req = 1'b0;
    chk("abort_start_hi", bus.game_start, 1);
    #2 rst = 1'b1;
    #1 chk("abort_start_async", bus.game_start, 0);
    @(posedge clk); #1 rst = 1'b0;
    tick();
    chk("abort_p1", bus.p1_score, 0);
    chk("abort_ready", bus.round_ready, 1);
    chk("abort_start_lo", bus.game_start, 0);

    // Stone vs scissors: P1 wins
    play(MV_STONE, MV_SCISSORS, 1'b0, 8'd0, '{2'b01, 4'd1, 4'd0, 4'd0, 1'b0, 2'b00, 1'b0});
    // Paper vs paper: tie
    play(MV_PAPER, MV_PAPER, 1'b0, 8'd0, '{2'b00, 4'd1, 4'd0, 4'd1, 1'b0, 2'b00, 1'b0});
    // Paper vs stone: second P1 win takes the match
    play(MV_PAPER, MV_STONE, 1'b0, 8'd0, '{2'b01, 4'd2, 4'd0, 4'd1, 1'b1, 2'b01, 1'b0});
    chk("done_ready", bus.round_ready, 0);
    chk("done_flag", bus.match_done, 1);
    bus.round_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("done_ignores_req", bus.game_start, 0);
    end
    bus.round_req = 1'b0;
    bus.match_clear = 1'b1;
    tick();
    bus.match_clear = 1'b0;
    chk("clr_p1", bus.p1_score, 0);
    chk("clr_tie", bus.tie_count, 0);
    chk("clr_done", bus.match_done, 0);
    chk("clr_winner", bus.match_winner, 0);
    chk("clr_ready", bus.round_ready, 1);

    // Move 11 forwarded; core answers 63, no proto_err
    play(2'b11, MV_STONE, 1'b0, 8'd0, '{2'b11, 4'd0, 4'd0, 4'd0, 1'b0, 2'b00, 1'b0});
    // Illegal result code 7 sets proto_err, no score change
    play(MV_STONE, MV_STONE, 1'b1, 8'd7, '{2'b11, 4'd0, 4'd0, 4'd0, 1'b0, 2'b00, 1'b1});
    // P2 win via scissors beating paper
    play(MV_PAPER, MV_SCISSORS, 1'b0, 8'd0, '{2'b10, 4'd0, 4'd1, 4'd0, 1'b0, 2'b00, 1'b1});

    // Clear and request together in IDLE: clear only
    wait_ready();
    bus.match_clear = 1'b1; bus.round_req = 1'b1;
    tick();
    bus.match_clear = 1'b0; bus.round_req = 1'b0;
    chk("clr_req_start", bus.game_start, 0);
    chk("clr_req_perr", bus.proto_err, 0);
    chk("clr_req_p2", bus.p2_score, 0);
    tick();
    chk("clr_req_start2", bus.game_start, 0);

    // Continuous request: accepts spaced exactly 4 cycles
    bus.p1_sel = MV_SCISSORS; bus.p2_sel = MV_SCISSORS;
    sbq.push_back('{2'b00, 4'd0, 4'd0, 4'd1, 1'b0, 2'b00, 1'b0});
    sbq.push_back('{2'b00, 4'd0, 4'd0, 4'd2, 1'b0, 2'b00, 1'b0});
    sbq.push_back('{2'b00, 4'd0, 4'd0, 4'd3, 1'b0, 2'b00, 1'b0});
    bus.round_req = 1'b1;
    last = 0;
    for (int k = 0; k < 3; k++) begin
      w = 0;
      do begin
        gs_before = bus.game_start;
        tick();
        w++;
      end while (!(bus.game_start && !gs_before) && w < 20);
      chk("accept_timeout", (w < 20) ? 1 : 0, 1);
      if (k > 0) chk("accept_spacing", cyc - last, 4);
      last = cyc;
    end
    bus.round_req = 1'b0;
    repeat (5) tick();
    chk("cont_tie_count", bus.tie_count, 3);
    chk("sb_drained", sbq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
